// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: serializes accepted bytes one bit per cycle into a PAT_W-bit
// detect window, reporting registered pattern matches, frame ends and a saturating count.
module seq_scan_ctrl #(
  parameter int unsigned      PAT_W   = 8,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = PAT_W'(8'hD5)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [PAT_W-1:0] cfg_pattern,
  output logic             cfg_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  input  logic             msb_first,
  output logic             match_pulse,
  output logic [2:0]       match_pos,
  output logic [CNT_W-1:0] match_count,
  output logic             busy,
  output logic             done
);

  localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pattern_q, pattern_d;
  logic [PAT_W-1:0]  window_q, window_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [2:0]        idx_q, idx_d;
  logic [7:0]        hold_q, hold_d;
  logic              last_q, last_d;
  logic              msbf_q, msbf_d;
  logic              match_pulse_q, match_pulse_d;
  logic [2:0]        match_pos_q, match_pos_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              cfg_err_q, cfg_err_d;

  logic              ready_c;
  logic              accept;
  logic              shift_bit;
  logic [PAT_W-1:0]  window_shift;
  logic [FILL_W-1:0] fill_inc;

  assign shift_bit    = msbf_q ? hold_q[3'd7 - idx_q] : hold_q[idx_q];
  assign window_shift = {window_q[PAT_W-2:0], shift_bit};
  assign fill_inc     = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d       = state_q;
    pattern_d     = pattern_q;
    window_d      = window_q;
    fill_d        = fill_q;
    idx_d         = idx_q;
    hold_d        = hold_q;
    last_d        = last_q;
    msbf_d        = msbf_q;
    match_pulse_d = 1'b0;
    match_pos_d   = match_pos_q;
    count_d       = count_q;
    cfg_err_d     = 1'b0;
    ready_c       = 1'b0;
    accept        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_c = !cfg_we;
        if (cfg_we) begin
          pattern_d = cfg_pattern;
          window_d  = '0;
          fill_d    = '0;
          count_d   = '0;
        end else if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        cfg_err_d = cfg_we;
        window_d  = window_shift;
        fill_d    = fill_inc;
        idx_d     = idx_q + 3'd1;
        // Compare the post-shift window so the pulse lands one cycle after its bit.
        if (window_shift == pattern_q && fill_inc == FILL_FULL) begin
          match_pulse_d = 1'b1;
          match_pos_d   = idx_q;
          if (count_q != '1) count_d = count_q + CNT_W'(1);
        end
        if (idx_q == 3'd7) begin
          if (last_q) begin
            state_d = ST_DONE;
          end else begin
            ready_c = 1'b1;
            if (in_valid) accept = 1'b1;
            else          state_d = ST_IDLE;
          end
        end
      end
      ST_DONE: begin
        cfg_err_d = cfg_we;
        window_d  = '0;
        fill_d    = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      hold_d = in_data;
      last_d = in_last;
      msbf_d = msb_first;
      idx_d  = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      pattern_q     <= RST_PAT;
      window_q      <= '0;
      fill_q        <= '0;
      idx_q         <= '0;
      hold_q        <= '0;
      last_q        <= 1'b0;
      msbf_q        <= 1'b0;
      match_pulse_q <= 1'b0;
      match_pos_q   <= '0;
      count_q       <= '0;
      cfg_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pattern_q     <= pattern_d;
      window_q      <= window_d;
      fill_q        <= fill_d;
      idx_q         <= idx_d;
      hold_q        <= hold_d;
      last_q        <= last_d;
      msbf_q        <= msbf_d;
      match_pulse_q <= match_pulse_d;
      match_pos_q   <= match_pos_d;
      count_q       <= count_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign in_ready    = ready_c && !rst;
  assign cfg_err     = cfg_err_q;
  assign match_pulse = match_pulse_q;
  assign match_pos   = match_pos_q;
  assign match_count = count_q;
  assign busy        = (state_q == ST_SHIFT);
  assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// tb_seq_scan_ctrl: drives byte frames through seq_scan_ctrl and compares matches,
// their cycles, done pulses and the count against a bit-list scanning model.
module tb_seq_scan_ctrl;
  localparam int PAT_W   = 8;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst, cfg_we, cfg_err, in_valid, in_ready, in_last, msb_first;
  logic [PAT_W-1:0] cfg_pattern;
  logic [7:0]       in_data;
  logic             match_pulse, busy, done;
  logic [2:0]       match_pos;
  logic [CNT_W-1:0] match_count;

  seq_scan_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W), .RST_PAT(8'hD5)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .msb_first(msb_first), .match_pulse(match_pulse), .match_pos(match_pos),
    .match_count(match_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int obs_cyc[$];
  int obs_pos[$];
  int done_cyc[$];
  always @(negedge clk) begin
    if (match_pulse) begin
      obs_cyc.push_back(cyc);
      obs_pos.push_back(int'(match_pos));
    end
    if (done) done_cyc.push_back(cyc);
  end

  logic [7:0] fr_data[$];
  bit         fr_msbf[$];
  logic [7:0] model_pat;
  int         exp_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fr_clear();
    fr_data.delete();
    fr_msbf.delete();
  endtask

  task automatic add_byte(input logic [7:0] d, input bit m);
    fr_data.push_back(d);
    fr_msbf.push_back(m);
  endtask

  // Waits for in_ready with in_valid held; optionally pokes cfg_we mid-shift.
  task automatic wait_ready(input bit poke, output int a, output bit ok);
    int w = 0;
    ok = 1'b1;
    while (!in_ready) begin
      step();
      w++;
      if (poke) begin
        if (w == 2) begin
          cfg_we = 1'b1;
          cfg_pattern = ~model_pat;
        end else if (w == 3) begin
          check("cfg_err_pulse", cfg_err, 1);
          cfg_we = 1'b0;
        end else if (w == 4) begin
          check("cfg_err_clear", cfg_err, 0);
        end
      end
      if (w > 40) begin
        check("ready_timeout", in_ready, 1);
        ok = 1'b0;
        break;
      end
    end
    a = cyc + 1;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input bit with_valid);
    cfg_we = 1'b1;
    cfg_pattern = pat;
    in_valid = with_valid;
    in_data = 8'h3C;
    in_last = 1'b1;
    #1 check("cfg_ready_low", in_ready, 0);
    step();
    cfg_we = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    #1;
    check("cfg_no_accept", busy, 0);
    check("cfg_count_clr", match_count, 0);
    model_pat = pat;
    exp_count = 0;
  endtask

  task automatic send_frame(input bit gaps, input bit poke);
    int acc[$];
    int exp_c[$];
    int exp_p[$];
    bit bits[$];
    int n, a, v, nb;
    bit ok, gapped;
    logic [7:0] by;
    n = fr_data.size();
    ok = 1'b1;
    gapped = 1'b0;
    obs_cyc.delete();
    obs_pos.delete();
    done_cyc.delete();
    for (int b = 0; b < n; b++) begin
      in_valid = 1'b1;
      in_data = fr_data[b];
      in_last = (b == n - 1);
      msb_first = fr_msbf[b];
      wait_ready(poke && b == 1, a, ok);
      if (!ok) break;
      acc.push_back(a);
      step();
      if (b > 0 && !gapped) check("b2b_spacing", acc[b] - acc[b-1], 8);
      gapped = 1'b0;
      if (gaps && b < n - 1 && $urandom_range(1) == 1) begin
        in_valid = 1'b0;
        gapped = 1'b1;
        repeat ($urandom_range(1, 12)) step();
      end
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    repeat (11) step();
    if (!ok) return;

    foreach (fr_data[b]) begin
      by = fr_data[b];
      for (int k = 0; k < 8; k++) bits.push_back(fr_msbf[b] ? by[7-k] : by[k]);
    end
    nb = bits.size();
    for (int i = PAT_W - 1; i < nb; i++) begin
      v = 0;
      for (int j = i - PAT_W + 1; j <= i; j++) v = (v << 1) | int'(bits[j]);
      if (v == int'(model_pat)) begin
        exp_c.push_back(acc[i/8] + i % 8 + 1);
        exp_p.push_back(i % 8);
        if (exp_count < CNT_MAX) exp_count++;
      end
    end

    check("n_match", obs_cyc.size(), exp_c.size());
    for (int i = 0; i < exp_c.size() && i < obs_cyc.size(); i++) begin
      check("match_cyc", obs_cyc[i], exp_c[i]);
      check("match_pos", obs_pos[i], exp_p[i]);
    end
    check("n_done", done_cyc.size(), 1);
    if (done_cyc.size() > 0) check("done_cyc", done_cyc[0], acc[n-1] + 8);
    check("count", match_count, exp_count);
  endtask

  initial begin
    int a1, a2, nbytes;
    bit ok;
    logic [7:0] by;
    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; msb_first = 1'b0;
    model_pat = 8'hD5;
    exp_count = 0;
    repeat (2) step();
    check("rst_ready_low", in_ready, 0);
    rst = 1'b0;
    #1;
    check("rst_ready_high", in_ready, 1);
    check("rst_count", match_count, 0);
    check("rst_pulse", match_pulse, 0);
    check("rst_pos", match_pos, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_err", cfg_err, 0);

    fr_clear(); add_byte(8'hD5, 1); send_frame(0, 0);
    check("single_count", match_count, 1);

    do_cfg(8'hD5, 0);
    fr_clear(); add_byte(8'h0D, 1); add_byte(8'h5F, 1); add_byte(8'h00, 1); send_frame(0, 0);
    check("xbyte_count", match_count, 1);
    do_cfg(8'hD5, 0);
    fr_clear(); add_byte(8'h0D, 1); send_frame(0, 0);
    fr_clear(); add_byte(8'h5F, 1); add_byte(8'h00, 1); send_frame(0, 0);
    check("split_count", match_count, 0);

    do_cfg(8'hAA, 0);
    fr_clear(); add_byte(8'hAA, 1); add_byte(8'hAA, 1); send_frame(0, 0);
    check("overlap_count", match_count, 5);

    do_cfg(8'hAB, 0);
    fr_clear(); add_byte(8'hD5, 0); send_frame(0, 0);
    check("lsb_count", match_count, 1);

    do_cfg(8'hD5, 1);
    fr_clear(); add_byte(8'h0D, 1); add_byte(8'h5F, 1); add_byte(8'h00, 1); send_frame(0, 1);
    check("poke_count", match_count, 1);

    obs_cyc.delete(); done_cyc.delete();
    in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1; msb_first = 1'b1;
    wait_ready(0, a1, ok);
    step();
    wait_ready(0, a2, ok);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    check("frame_gap", a2 - a1, 10);
    repeat (11) step();
    check("gap_done_cnt", done_cyc.size(), 2);
    check("gap_no_match", obs_cyc.size(), 0);

    do_cfg(8'h00, 0);
    fr_clear(); for (int i = 0; i < 32; i++) add_byte(8'h00, 1'($urandom)); send_frame(0, 0);
    check("sat_249", match_count, 249);
    do_cfg(8'h00, 0);
    fr_clear(); for (int i = 0; i < 33; i++) add_byte(8'h00, 1'($urandom)); send_frame(1, 0);
    check("sat_255", match_count, 255);
    fr_clear(); add_byte(8'h00, 1); add_byte(8'h00, 0); send_frame(0, 0);
    check("sat_hold", match_count, 255);

    do_cfg(8'h12, 0);
    fr_clear(); add_byte(8'h12, 1); send_frame(0, 0);
    check("pre_rst_count", match_count, 1);
    in_valid = 1'b1; in_data = 8'h12; in_last = 1'b1; msb_first = 1'b1;
    wait_ready(0, a1, ok);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (4) step();
    check("mid_busy", busy, 1);
    obs_cyc.delete(); done_cyc.delete();
    rst = 1'b1;
    step();
    check("mid_rst_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", match_count, 0);
    check("mid_rst_pos", match_pos, 0);
    check("mid_rst_pulse", match_pulse, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0;
    #1 check("mid_rst_ready_up", in_ready, 1);
    repeat (12) step();
    check("rst_no_match", obs_cyc.size(), 0);
    check("rst_no_done", done_cyc.size(), 0);
    model_pat = 8'hD5;
    exp_count = 0;
    fr_clear(); add_byte(8'h12, 1); send_frame(0, 0);
    fr_clear(); add_byte(8'hD5, 1); send_frame(0, 0);
    check("post_rst_count", match_count, 1);

    for (int f = 0; f < 25; f++) begin
      if ($urandom_range(3) == 0) begin
        case ($urandom_range(3))
          0:       by = 8'hAA;
          1:       by = 8'h00;
          default: by = 8'($urandom);
        endcase
        do_cfg(by, 1'($urandom));
      end
      fr_clear();
      nbytes = $urandom_range(1, 5);
      for (int b = 0; b < nbytes; b++) begin
        case ($urandom_range(3))
          0:       by = model_pat;
          1:       by = {model_pat[3:0], model_pat[7:4]};
          default: by = 8'($urandom);
        endcase
        add_byte(by, 1'($urandom));
      end
      send_frame(1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
